mem_stage_sram_ctrl: RTL and testbench

Memory stage that consumes the EXE/MEM pipeline register outputs and performs 32-bit data loads and stores against an external 16-bit asynchronous SRAM. Each word is moved as two half-word transfers, low half first. While an access is in flight the block holds `ready` low, and the pipeline uses it as a freeze. Results go to the MEM/WB register.

---
 rtl/mem_stage_sram_ctrl_if.sv | 45 ++++
 rtl/mem_stage_sram_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side and SRAM-side signals of the memory stage, grouped in one bundle.
// The master modport is the controller; the slave modport is the environment,
// meaning the pipeline registers plus the SRAM.
interface mem_stage_sram_ctrl_if #(
    parameter int SRAM_AW = 18
);
    // EXE/MEM -> memory stage
    logic               wb_en_in;
    logic               mem_r_en_in;
    logic               mem_w_en_in;
    logic [31:0]        alu_result_in;
    logic [31:0]        val_rm_in;
    logic [3:0]         dest_in;

    // memory stage -> MEM/WB and freeze
    logic               ready;
    logic               wb_en_out;
    logic               mem_r_en_out;
    logic [31:0]        alu_result_out;
    logic [3:0]         dest_out;
    logic [31:0]        mem_data_out;

    // SRAM pins
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;

    modport master (
        input  wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, val_rm_in, dest_in,
        output ready, wb_en_out, mem_r_en_out, alu_result_out, dest_out, mem_data_out,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
        input  sram_dq_in
    );

    modport slave (
        output wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, val_rm_in, dest_in,
        input  ready, wb_en_out, mem_r_en_out, alu_result_out, dest_out, mem_data_out,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
        output sram_dq_in
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: a 32-bit load/store is split into two 16-bit SRAM transfers,
// low half first. While the access is in flight, ready stays low and the
// pipeline freezes.
module mem_stage_sram_ctrl #(
    parameter int ADDR_OFFSET   = 1024,
    parameter int SRAM_AW       = 18,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_stage_sram_ctrl_if.master  bus
);
    localparam int             CW        = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(ACCESS_CYCLES - 1);
    // With single-cycle phases there is no spare cycle for write-data hold.
    localparam bit             HOLD_LAST = (ACCESS_CYCLES > 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_wr_q, is_wr_d;
    logic [SRAM_AW-1:0] base_q, base_d;      // even half-word address of the word
    logic [31:0]        wdata_q, wdata_d;
    logic [15:0]        lo_q, lo_d;          // low half of a load, waiting for the high half
    logic [31:0]        data_q, data_d;      // committed load data

    logic [SRAM_AW-1:0] addr_q;
    logic [15:0]        dq_out_q;
    logic               dq_oe_q, ce_n_q, oe_n_q, we_n_q;

    logic               req;
    logic               last;
    logic               in_phase_d;
    logic               last_d;
    logic [31:0]        off;
    logic               unused_off_bits;

    assign req  = bus.mem_r_en_in | bus.mem_w_en_in;
    assign off  = bus.alu_result_in - 32'(ADDR_OFFSET);
    assign last = (cnt_q == CNT_LAST);
    // The byte-lane bits and the bits above the SRAM range take no part in the address.
    assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};

    // Pass-throughs are combinational, so non-memory instructions add no latency.
    assign bus.ready          = rst | (state_q == DONE) | ((state_q == IDLE) & ~req);
    assign bus.wb_en_out      = bus.wb_en_in & bus.ready;
    assign bus.mem_r_en_out   = bus.mem_r_en_in & bus.ready;
    assign bus.alu_result_out = bus.alu_result_in;
    assign bus.dest_out       = bus.dest_in;
    assign bus.mem_data_out   = data_q;

    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;

    // Next state: sequence IDLE -> LO -> HI -> DONE and capture read halves.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LO;
                    cnt_d   = '0;
                    is_wr_d = bus.mem_w_en_in;   // store wins when both are set
                    base_d  = {off[SRAM_AW:2], 1'b0};
                    wdata_d = bus.val_rm_in;
                end
            end
            LO: begin
                if (last) begin
                    state_d = HI;
                    cnt_d   = '0;
                    if (!is_wr_q) lo_d = bus.sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HI: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    // Commit the whole word at once so a load's old value stays visible until then.
                    if (!is_wr_q) data_d = {bus.sram_dq_in, lo_q};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The pipeline advances on DONE, so the still-present request is not restarted.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_phase_d = (state_d == LO) || (state_d == HI);
        last_d     = (cnt_d == CNT_LAST);
    end

    // State registers and SRAM pin registers; pins are computed from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_wr_q  <= 1'b0;
            base_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            if (in_phase_d) begin
                addr_q   <= {base_d[SRAM_AW-1:1], state_d == HI};
                ce_n_q   <= 1'b0;
                oe_n_q   <= is_wr_d;
                // Release WE one cycle early so the data is held past the write edge.
                we_n_q   <= ~is_wr_d | (last_d & HOLD_LAST);
                dq_oe_q  <= is_wr_d;
                dq_out_q <= !is_wr_d ? 16'h0 :
                            (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
            end else begin
                addr_q   <= '0;
                ce_n_q   <= 1'b1;
                oe_n_q   <= 1'b1;
                we_n_q   <= 1'b1;
                dq_oe_q  <= 1'b0;
                dq_out_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl. It uses a word-level memory model, a
// directed table, random operations, and hand sequences for reset and timing
// corners. A second instance runs with single-cycle phases.
module tb_mem_stage_sram_ctrl;
    localparam int AC_A = 2;
    localparam int AC_B = 1;

    logic clk;
    logic rst;
    logic sram_clr;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_stage_sram_ctrl_if #(.SRAM_AW(18)) ifa ();
    mem_stage_sram_ctrl_if #(.SRAM_AW(18)) ifb ();

    mem_stage_sram_ctrl #(.ADDR_OFFSET(1024), .SRAM_AW(18), .ACCESS_CYCLES(AC_A))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mem_stage_sram_ctrl #(.ADDR_OFFSET(1024), .SRAM_AW(18), .ACCESS_CYCLES(AC_B))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Half-word SRAM behind dut_a: reads are asynchronous, writes are captured while WE is low.
    logic [15:0] sram_a [0:255];
    always @(posedge clk) begin
        if (sram_clr) begin
            for (int i = 0; i < 256; i++) sram_a[i] <= 16'h0;
        end else if (!ifa.sram_ce_n && !ifa.sram_we_n && ifa.sram_dq_oe) begin
            sram_a[ifa.sram_addr[7:0]] <= ifa.sram_dq_out;
        end
    end
    assign ifa.sram_dq_in = (!ifa.sram_ce_n && !ifa.sram_oe_n) ? sram_a[ifa.sram_addr[7:0]] : 16'h0;
    // dut_b sees a fixed pattern: odd half-words read 0x2222, even ones read 0x1111.
    assign ifb.sram_dq_in = (!ifb.sram_ce_n && !ifb.sram_oe_n) ?
                            (ifb.sram_addr[0] ? 16'h2222 : 16'h1111) : 16'h0;

    // Word-level reference memory.
    logic [31:0] ref_mem [int];

    function automatic int word_idx(input logic [31:0] alu);
        logic [31:0] o;
        o = alu - 32'd1024;
        return int'((o >> 2) & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wb, input logic rd, input logic wr,
                         input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
        ifa.wb_en_in      = wb;
        ifa.mem_r_en_in   = rd;
        ifa.mem_w_en_in   = wr;
        ifa.alu_result_in = alu;
        ifa.val_rm_in     = val;
        ifa.dest_in       = dest;
    endtask

    // Issue one instruction to dut_a and check the freeze length, the pin
    // sequence in every phase cycle, the DONE-cycle outputs and the load data.
    task automatic run_op(input string nm, input logic wb, input logic rd, input logic wr,
                          input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest,
                          input logic chk_data, input logic [31:0] exp_data);
        int          k, bad_pat, bad_frz, ph, c, exp_stall;
        logic        mem;
        logic [17:0] base;
        logic        e_we;
        logic [15:0] e_dq;
        mem       = rd | wr;
        exp_stall = mem ? 2 * AC_A + 1 : 0;
        base      = 18'(word_idx(alu) * 2);
        @(posedge clk); #1;
        drive(wb, rd, wr, alu, val, dest);
        #1;
        chk({nm, " alu pass"}, ifa.alu_result_out, alu);
        chk({nm, " dest pass"}, 32'(ifa.dest_out), 32'(dest));
        chk({nm, " ready T0"}, 32'(ifa.ready), 32'(!mem));
        k = 0; bad_pat = 0; bad_frz = 0;
        while (!ifa.ready && k < 4 * AC_A + 8) begin
            if (ifa.wb_en_out || ifa.mem_r_en_out) bad_frz++;
            @(posedge clk); #2;
            k++;
            if (mem && k <= 2 * AC_A) begin
                ph   = (k - 1) / AC_A;
                c    = (k - 1) % AC_A;
                e_we = wr ? (c == AC_A - 1 && AC_A > 1) : 1'b1;
                e_dq = !wr ? 16'h0 : (ph == 1 ? val[31:16] : val[15:0]);
                if (ifa.sram_ce_n !== 1'b0 || ifa.sram_addr !== (base | 18'(ph)) ||
                    ifa.sram_we_n !== e_we || ifa.sram_oe_n !== wr ||
                    ifa.sram_dq_oe !== wr || ifa.sram_dq_out !== e_dq) bad_pat++;
            end
        end
        chk({nm, " stall cycles"}, 32'(k), 32'(exp_stall));
        chk({nm, " wb_en_out at ready"}, 32'(ifa.wb_en_out), 32'(wb));
        chk({nm, " mem_r_en_out at ready"}, 32'(ifa.mem_r_en_out), 32'(rd));
        chk({nm, " ce_n at ready"}, 32'(ifa.sram_ce_n), 32'd1);
        if (mem) begin
            chk({nm, " pin sequence errors"}, 32'(bad_pat), 32'd0);
            chk({nm, " outputs leaked while frozen"}, 32'(bad_frz), 32'd0);
        end
        if (chk_data) chk({nm, " mem_data_out"}, ifa.mem_data_out, exp_data);
        if (wr) ref_mem[word_idx(alu)] = val;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    typedef struct {
        string       nm;
        logic        wb, rd, wr;
        logic [31:0] alu, val;
        logic [3:0]  dest;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic wb, input logic rd, input logic wr,
                                input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest,
                                input logic cd, input logic [31:0] ed);
        vec_t v;
        v.nm = nm; v.wb = wb; v.rd = rd; v.wr = wr; v.alu = alu; v.val = val;
        v.dest = dest; v.chk_data = cd; v.exp_data = ed;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [7];
        int          k, kind, w;
        logic [31:0] alu, val;
        logic [17:0] a1, a2;
        logic        we1, we2;

        tbl[0] = mk("store 1028",     1'b0, 1'b0, 1'b1, 32'd1028,     32'hDEADBEEF, 4'd0,  1'b1, 32'h0);
        tbl[1] = mk("load 1028",      1'b1, 1'b1, 1'b0, 32'd1028,     32'h0,        4'd3,  1'b1, 32'hDEADBEEF);
        tbl[2] = mk("alu 0x1234",     1'b1, 1'b0, 1'b0, 32'h1234,     32'h5555,     4'd7,  1'b1, 32'hDEADBEEF);
        tbl[3] = mk("store-wins",     1'b1, 1'b1, 1'b1, 32'd1032,     32'hCAFEF00D, 4'd2,  1'b1, 32'hDEADBEEF);
        tbl[4] = mk("load 1032",      1'b1, 1'b1, 1'b0, 32'd1032,     32'h0,        4'd4,  1'b1, 32'hCAFEF00D);
        tbl[5] = mk("load 1031 low",  1'b1, 1'b1, 1'b0, 32'd1031,     32'h0,        4'd5,  1'b1, 32'hDEADBEEF);
        tbl[6] = mk("alu no wb",      1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        4'd15, 1'b0, 32'h0);

        // Reset held for two cycles with a load pending.
        rst = 1'b1; sram_clr = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, 4'h0);
        ifb.wb_en_in = 1'b0; ifb.mem_r_en_in = 1'b0; ifb.mem_w_en_in = 1'b0;
        ifb.alu_result_in = 32'h0; ifb.val_rm_in = 32'h0; ifb.dest_in = 4'h0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset ready", 32'(ifa.ready), 32'd1);
        chk("reset strobes", {29'h0, ifa.sram_ce_n, ifa.sram_oe_n, ifa.sram_we_n}, 32'h7);
        chk("reset dq_oe", 32'(ifa.sram_dq_oe), 32'd0);
        chk("reset mem_data_out", ifa.mem_data_out, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0; sram_clr = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op(tbl[i].nm, tbl[i].wb, tbl[i].rd, tbl[i].wr, tbl[i].alu, tbl[i].val,
                   tbl[i].dest, tbl[i].chk_data, tbl[i].exp_data);
        chk("sram[2] low half", 32'(sram_a[2]), 32'h0000BEEF);
        chk("sram[3] high half", 32'(sram_a[3]), 32'h0000DEAD);

        // Back-to-back loads: the held request restarts in the cycle after DONE.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd1);
        k = 0;
        @(posedge clk); #1;
        while (!ifa.ready && k < 20) begin @(posedge clk); #1; k++; end
        chk("b2b first data", ifa.mem_data_out, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("b2b restart ready low", 32'(ifa.ready), 32'd0);
        chk("b2b restart in idle", 32'(ifa.sram_ce_n), 32'd1);
        k = 0;
        while (!ifa.ready && k < 20) begin
            @(posedge clk); #1; k++;
            if (k == 1) chk("b2b LO after restart", {13'h0, ifa.sram_ce_n, ifa.sram_addr}, 32'h2);
        end
        chk("b2b second stall", 32'(k), 32'(2 * AC_A + 1));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Random operations checked against the word-level reference model.
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            w    = int'($urandom_range(0, 15));
            alu  = 32'd1024 + 32'(w * 4) + 32'($urandom_range(0, 3));
            val  = $urandom;
            if (kind == 0)
                run_op("rnd alu", 1'b1, 1'b0, 1'b0, $urandom, val, 4'($urandom), 1'b0, 32'h0);
            else if (kind == 1)
                run_op("rnd load", 1'($urandom), 1'b1, 1'b0, alu, val, 4'($urandom), 1'b1, ref_rd(w));
            else
                run_op("rnd store", 1'b0, 1'b0, 1'b1, alu, val, 4'($urandom), 1'b0, 32'h0);
        end

        // Reset during the HI phase of a store to word 31, which is never loaded afterwards.
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'd1148, 32'h12345678, 4'h0);
        @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
        chk("mid-store in HI", {13'h0, ifa.sram_we_n, ifa.sram_addr}, 32'd63);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid-store rst we_n", 32'(ifa.sram_we_n), 32'd1);
        chk("mid-store rst dq_oe", 32'(ifa.sram_dq_oe), 32'd0);
        chk("mid-store rst mem_data", ifa.mem_data_out, 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        chk("after rst ready", 32'(ifa.ready), 32'd1);
        chk("after rst ce_n", 32'(ifa.sram_ce_n), 32'd1);
        run_op("load after rst", 1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd9, 1'b1, ref_rd(1));

        // Single-cycle phases: a load at 1023 wraps to the top of the SRAM.
        @(posedge clk); #1;
        ifb.mem_r_en_in = 1'b1; ifb.wb_en_in = 1'b1; ifb.alu_result_in = 32'd1023;
        #1;
        k = 0; a1 = '0; a2 = '0;
        while (!ifb.ready && k < 10) begin
            @(posedge clk); #2; k++;
            if (k == 1) a1 = ifb.sram_addr;
            if (k == 2) a2 = ifb.sram_addr;
        end
        chk("ac1 load stall", 32'(k), 32'(2 * AC_B + 1));
        chk("ac1 LO addr", 32'(a1), 32'h3FFFE);
        chk("ac1 HI addr", 32'(a2), 32'h3FFFF);
        chk("ac1 load data", ifb.mem_data_out, 32'h22221111);
        chk("ac1 mem_r_en_out at ready", 32'(ifb.mem_r_en_out), 32'd1);
        ifb.mem_r_en_in = 1'b0; ifb.wb_en_in = 1'b0;

        // Single-cycle phases: WE stays low for the only cycle of each phase.
        @(posedge clk); #1;
        ifb.mem_w_en_in = 1'b1; ifb.val_rm_in = 32'hA5A55A5A;
        #1;
        k = 0; we1 = 1'b1; we2 = 1'b1;
        while (!ifb.ready && k < 10) begin
            @(posedge clk); #2; k++;
            if (k == 1) we1 = ifb.sram_we_n;
            if (k == 2) we2 = ifb.sram_we_n;
        end
        chk("ac1 store stall", 32'(k), 32'(2 * AC_B + 1));
        chk("ac1 store we_n", {30'h0, we1, we2}, 32'h0);
        ifb.mem_w_en_in = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
